// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the four-channel TDM demultiplexer slice.
//
// Contents:
//   tdm_state_t  - receive FSM encoding (IDLE = 0, RECV = 1)
//   N_CH         - number of time-multiplexed channels per frame
//   SLOT_W       - width of the slot counter
//   LAST_SLOT    - index of the final slot in a frame
//   is_last_slot - helper returning 1 when a slot index is the final slot
// ---------------------------------------------------------------------------
package tdm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } tdm_state_t;

   localparam int N_CH   = 4;
   localparam int SLOT_W = 2;

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);

   function automatic logic is_last_slot(input logic [SLOT_W-1:0] slot);
      return (slot == LAST_SLOT);
   endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// ---------------------------------------------------------------------------
// tdm_slot_counter
// Slot index for the frame currently being collected. The count saturates at
// the final slot instead of wrapping; the only way back to zero is an
// explicit clear (issued when the receiver returns to IDLE) or reset.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous reset, active low
//   clear    in   force the slot index to 0 (highest priority)
//   load_one in   force the slot index to 1 (ch0 has just been stored)
//   incr     in   advance to the next slot (ignored at the final slot)
//   slot     out  current slot index, SLOT_W bits
// ---------------------------------------------------------------------------
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load_one,
   input  logic              incr,
   output logic [SLOT_W-1:0] slot
);

   // Priority is clear > load > increment. A sof beat always restarts the
   // count at 1 because its data lands in ch0 on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
      end else if (clear) begin
         slot <= '0;
      end else if (load_one) begin
         slot <= SLOT_W'(1);
      end else if (incr && !is_last_slot(slot)) begin
         slot <= slot + SLOT_W'(1);
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// ---------------------------------------------------------------------------
// tdm_demux4
// Collects four consecutive time-multiplexed samples (slot 0 flagged by sof)
// into staging registers and publishes them as one wide word once the frame
// is complete. A new sof arriving mid-frame aborts the partial frame with an
// error pulse and starts collecting again from the new beat.
//
// Parameters:
//   W            data width per channel (default 8)
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   in_valid     in   in_data carries a beat this cycle
//   in_sof       in   start of frame (slot-0 beat), qualified by in_valid
//   in_data      in   W-bit channel sample
//   in_par       in   even parity over in_data (TDM_DEMUX_PARITY_EN only)
//   out_data     out  {ch3,ch2,ch1,ch0} of the last complete frame
//   frame_valid  out  one-cycle pulse, out_data updated this cycle
//   frame_err    out  one-cycle pulse, current frame discarded
//   busy         out  high while a frame is partially received
//
// Configuration macro:
//   TDM_DEMUX_PARITY_EN  adds in_par and discards a frame on any beat whose
//                        parity does not match.
// ---------------------------------------------------------------------------
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [W-1:0]      in_data,
`ifdef TDM_DEMUX_PARITY_EN
   input  logic              in_par,
`endif
   output logic [N_CH*W-1:0] out_data,
   output logic              frame_valid,
   output logic              frame_err,
   output logic              busy
);

   tdm_state_t        state;
   tdm_state_t        state_next;

   logic              frame_full;
   logic              frame_full_next;

   logic [W-1:0]      stage [N_CH];
   logic              stage_we;
   logic [SLOT_W-1:0] stage_sel;

   logic              capture;
   logic              err_next;

   logic              slot_clear;
   logic              slot_load;
   logic              slot_incr;
   logic [SLOT_W-1:0] slot;

   logic              beat_ok;

   // A beat is usable only when its parity matches; without the parity
   // option every beat is usable.
`ifdef TDM_DEMUX_PARITY_EN
   assign beat_ok = ~(^in_data ^ in_par);
`else
   assign beat_ok = 1'b1;
`endif

   tdm_slot_counter u_slot_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (slot_clear),
      .load_one (slot_load),
      .incr     (slot_incr),
      .slot     (slot)
   );

   // State register together with the "all four slots stored" flag. The flag
   // keeps the FSM at two states: RECV with frame_full set is the single
   // cycle in which the completed frame is published.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         frame_full <= 1'b0;
      end else begin
         state      <= state_next;
         frame_full <= frame_full_next;
      end
   end

   // Next-state and datapath control. The publish cycle takes priority over
   // any beat arriving with it: a clean sof beat there starts the next frame
   // straight away, anything else is dropped without an error so that
   // frame_valid and frame_err can never coincide.
   always_comb begin
      state_next      = state;
      frame_full_next = frame_full;
      stage_we        = 1'b0;
      stage_sel       = '0;
      capture         = 1'b0;
      err_next        = 1'b0;
      slot_clear      = 1'b0;
      slot_load       = 1'b0;
      slot_incr       = 1'b0;

      unique case (state)
         IDLE: begin
            if (in_valid && in_sof) begin
               if (beat_ok) begin
                  stage_we   = 1'b1;
                  slot_load  = 1'b1;
                  state_next = RECV;
               end else begin
                  err_next   = 1'b1;
               end
            end
         end

         RECV: begin
            if (frame_full) begin
               capture         = 1'b1;
               frame_full_next = 1'b0;
               if (in_valid && in_sof && beat_ok) begin
                  stage_we   = 1'b1;
                  slot_load  = 1'b1;
               end else begin
                  state_next = IDLE;
                  slot_clear = 1'b1;
               end
            end else if (in_valid) begin
               if (!beat_ok) begin
                  err_next   = 1'b1;
                  state_next = IDLE;
                  slot_clear = 1'b1;
               end else if (in_sof) begin
                  err_next   = 1'b1;
                  stage_we   = 1'b1;
                  slot_load  = 1'b1;
               end else begin
                  stage_we  = 1'b1;
                  stage_sel = slot;
                  if (is_last_slot(slot)) begin
                     frame_full_next = 1'b1;
                  end else begin
                     slot_incr = 1'b1;
                  end
               end
            end
         end

         default: begin
            state_next = IDLE;
            slot_clear = 1'b1;
         end
      endcase
   end

   // Staging registers; a sof beat always targets ch0 because stage_sel
   // defaults to zero on every path except a mid-frame store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            stage[i] <= '0;
         end
      end else if (stage_we) begin
         stage[stage_sel] <= in_data;
      end
   end

   // Published frame and status pulses. out_data moves only together with
   // frame_valid, so it always holds the last complete frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data    <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         if (capture) begin
            out_data <= {stage[3], stage[2], stage[1], stage[0]};
         end
         frame_valid <= capture;
         frame_err   <= err_next;
      end
   end

   assign busy = (state == RECV);

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the data width per channel in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data holds a beat this cycle.
REQ-005 The block SHALL have port in_sof, input, 1 bit: start of frame; qualified by in_valid; marks the slot-0 beat.
REQ-006 The block SHALL have port in_data, input, W bits: one time-multiplexed channel sample.
REQ-007 The block SHALL have port in_par, input, 1 bit: even parity over in_data; present only with TDM_DEMUX_PARITY_EN.
REQ-008 The block SHALL have port out_data, output, 4*W bits: {ch3,ch2,ch1,ch0}, holding the last complete frame.
REQ-009 The block SHALL have port frame_valid, output, 1 bit: single-cycle pulse, out_data updated this cycle.
REQ-010 The block SHALL have port frame_err, output, 1 bit: single-cycle pulse, current frame discarded.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a frame is partially received.

Function
REQ-012 The block SHALL use a two-state FSM: IDLE (waiting for sof) and RECV (collecting slots 1..3).
REQ-013 In IDLE, a beat with in_sof=1 SHALL store in_data into the ch0 staging register, set slot=1 and move to RECV.
REQ-014 In IDLE, a beat with in_sof=0 SHALL be dropped silently, with no error raised.
REQ-015 In RECV, a beat with in_sof=0 SHALL store into staging register [slot] and increment slot.
REQ-016 When slot 3 is stored, the next edge SHALL copy all four staging registers to out_data, pulse frame_valid and return to IDLE with slot=0; latency is 1 cycle after the slot-3 beat.
REQ-017 In RECV, a beat with in_sof=1 SHALL pulse frame_err, discard the partial frame, store the beat as the new ch0, set slot=1 and stay in RECV.
REQ-018 Cycles with in_valid=0 SHALL leave all state unchanged; gaps of any length are legal.
REQ-019 out_data SHALL change only on a frame_valid cycle.
REQ-020 frame_valid and frame_err SHALL never be high in the same cycle.
REQ-021 busy SHALL equal (state==RECV).
REQ-022 The slot counter SHALL be 2 bits and SHALL never wrap within RECV; it SHALL return to 0 only via IDLE.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately set the state to IDLE, slot=0, out_data=0, frame_valid=0, frame_err=0 and busy=0, and clear the staging registers.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame without pulsing frame_err.
REQ-025 The first beat accepted after reset release SHALL be one on the first rising clk edge with rst_n=1.

Configuration
REQ-026 When the macro TDM_DEMUX_PARITY_EN is defined, the in_par port SHALL exist and each accepted beat SHALL be checked against it.
REQ-027 With TDM_DEMUX_PARITY_EN defined, a parity mismatch SHALL pulse frame_err, discard the frame and return to IDLE, including on a sof beat.
REQ-028 Without TDM_DEMUX_PARITY_EN, the in_par port SHALL be absent and no parity logic SHALL be present.

Structure
REQ-029 The shared package tdm_pkg SHALL hold the FSM state encoding (IDLE=0, RECV=1), the constant N_CH=4 and the slot width of 2.
REQ-030 The slot counter with load/increment/clear SHALL be the sub-module tdm_slot_counter; all other logic SHALL be in tdm_demux4.

Verification
REQ-031 Reset, then the beats sof:0x11, 0x22, 0x33, 0x44 SHALL give out_data=0x44332211 and one frame_valid pulse one cycle after 0x44.
REQ-032 The same frame with 3 idle cycles between each beat SHALL give an identical out_data and a single frame_valid pulse.
REQ-033 The beats sof:0xAA, 0xBB, then sof:0x01, 0x02, 0x03, 0x04 SHALL give a frame_err pulse at the second sof, then out_data=0x04030201.
REQ-034 Beats without sof while in IDLE (0x55, 0x66) SHALL cause no output change and no pulses.
REQ-035 rst_n pulled low after two beats SHALL clear all outputs at once; a full frame after release SHALL then be received correctly.
REQ-036 With TDM_DEMUX_PARITY_EN defined, in_data=0x03 with in_par=1 on slot 2 SHALL pulse frame_err, leave out_data unchanged and set busy=0.
